// File: rtl/alu_issue_if.sv
// Handshake bundle for alu_issue_ctrl: upstream op request and downstream result.
interface alu_issue_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [3:0]        in_op;
  logic              in_use_acc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_res;
  logic              out_ovfl;
  logic              out_dz;

  modport master (
    output in_valid, in_a, in_b, in_op, in_use_acc, out_ready,
    input  in_ready, out_valid, out_res, out_ovfl, out_dz
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_use_acc, out_ready,
    output in_ready, out_valid, out_res, out_ovfl, out_dz
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/capture stage around an 8-bit combinational ALU (IDLE -> EXEC -> HOLD).
// Optional op_count transaction counter enabled by macro ALU_ISSUE_OPCOUNT_EN.
module alu_issue_ctrl #(
  parameter int DATA_W      = 8,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_if.slave        bus,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [3:0]        alu_op_o,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic              alu_ovfl_i,
  output logic [15:0]       op_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);
  localparam logic [3:0] OP_DIV   = 4'b0011;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              ovfl_q, ovfl_d;
  logic              dz_q, dz_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              div_zero_s;
  logic [DATA_W-1:0] cap_res_s;
  logic              cap_ovfl_s;

  // A zero divisor overrides whatever the ALU drives so no X reaches the result.
  assign div_zero_s = (alu_op_q == OP_DIV) && (alu_b_q == {DATA_W{1'b0}});
  assign cap_res_s  = div_zero_s ? {DATA_W{1'b1}} : alu_res_i;
  assign cap_ovfl_s = div_zero_s ? 1'b0 : alu_ovfl_i;

  // Next-state and output-register logic for the issue/capture sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    acc_d       = acc_q;
    res_d       = res_q;
    ovfl_d      = ovfl_q;
    dz_d        = dz_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          alu_a_d  = bus.in_use_acc ? acc_q : bus.in_a;
          alu_b_d  = bus.in_b;
          alu_op_d = bus.in_op;
          cnt_d    = 4'd0;
          state_d  = EXEC;
        end else begin
          state_d  = IDLE;
        end
      end
      EXEC: begin
        if (cnt_q == LAST_CNT) begin
          res_d       = cap_res_s;
          ovfl_d      = cap_ovfl_s;
          dz_d        = div_zero_s;
          acc_d       = cap_res_s;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d       = cnt_q + 4'd1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    // Registered ready: low through reset, high from the first edge back in IDLE.
    in_ready_d = (state_d == IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      alu_a_q     <= {DATA_W{1'b0}};
      alu_b_q     <= {DATA_W{1'b0}};
      alu_op_q    <= 4'd0;
      acc_q       <= {DATA_W{1'b0}};
      res_q       <= {DATA_W{1'b0}};
      ovfl_q      <= 1'b0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      ovfl_q      <= ovfl_d;
      dz_q        <= dz_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_op_o      = alu_op_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = res_q;
  assign bus.out_ovfl  = ovfl_q;
  assign bus.out_dz    = dz_q;

`ifdef ALU_ISSUE_OPCOUNT_EN
  logic [15:0] op_count_q;

  // Counts results handed downstream; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= 16'h0000;
    end else if ((state_q == HOLD) && bus.out_ready) begin
      op_count_q <= op_count_q + 16'd1;
    end else begin
      op_count_q <= op_count_q;
    end
  end

  assign op_count_o = op_count_q;
`else
  assign op_count_o = 16'h0000;
`endif

endmodule
